// File: rtl/port_in_fifo.sv
// Port-bus input peripheral: buffers 16-bit event words in a small FIFO,
// exposes data/status on in_port by port_id and raises an acknowledged interrupt.
module port_in_fifo #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DATA_PORT = 16'h0002,
  parameter logic [15:0] STAT_PORT = 16'h0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_tick,
  input  logic [15:0] wr_data,
  input  logic [15:0] port_id,
  input  logic        read_strobe,
  input  logic        interrupt_ack,
  output logic [15:0] in_port,
  output logic        interrupt,
  output logic        overflow
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  state_t        state, state_nxt;

  logic rd_data, rd_stat, empty, full, push, pop;

  assign rd_data = read_strobe & (port_id == DATA_PORT);
  assign rd_stat = read_strobe & (port_id == STAT_PORT);
  assign empty   = (count == 5'd0);
  assign full    = (count == DEPTH_C);
  assign pop     = rd_data & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push    = wr_tick & (~full | pop);

  always_comb begin
    in_port = 16'h0000;
    if (port_id == DATA_PORT) begin
      if (!empty) in_port = mem[rd_ptr];
    end else if (port_id == STAT_PORT) begin
      in_port = {overflow, full, empty, 8'b0, count};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= 5'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 5'd1;
      else if (pop && !push) count <= count - 5'd1;
      // Dropping a word takes priority over a status-read clear.
      if (wr_tick && full && !pop) overflow <= 1'b1;
      else if (rd_stat)            overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)             state_nxt = REQ;
      REQ:     if (interrupt_ack)      state_nxt = SERVICE;
      SERVICE: if (rd_data || rd_stat) state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  assign interrupt = (state == REQ);

endmodule

// File: tb/tb_port_in_fifo.sv
// Directed bench for port_in_fifo: reset, push/pop, overflow, full-with-pop,
// pointer wrap and the interrupt handshake including asynchronous reset.
module tb_port_in_fifo;

  localparam logic [15:0] DATA_PORT = 16'h0002;
  localparam logic [15:0] STAT_PORT = 16'h0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_tick;
  logic [15:0] wr_data;
  logic [15:0] port_id;
  logic        read_strobe;
  logic        interrupt_ack;
  logic [15:0] in_port;
  logic        interrupt;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  port_in_fifo #(.DEPTH(8), .DATA_PORT(DATA_PORT), .STAT_PORT(STAT_PORT)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_tick       (wr_tick),
    .wr_data       (wr_data),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_tick = 1'b1;
    wr_data = d;
    cycle();
    wr_tick = 1'b0;
  endtask

  task automatic rd(input logic [15:0] pid);
    port_id     = pid;
    read_strobe = 1'b1;
    cycle();
    read_strobe = 1'b0;
  endtask

  task automatic status_is(input string tag, input logic [15:0] exp);
    port_id = STAT_PORT;
    #1;
    chk(tag, in_port, exp);
  endtask

  task automatic head_is(input string tag, input logic [15:0] exp);
    port_id = DATA_PORT;
    #1;
    chk(tag, in_port, exp);
  endtask

  // ack then status read: walks REQ -> SERVICE -> IDLE with an empty FIFO
  task automatic settle_irq();
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
    rd(STAT_PORT);
  endtask

  initial begin
    rst = 1'b0; wr_tick = 1'b0; wr_data = '0; port_id = STAT_PORT;
    read_strobe = 1'b0; interrupt_ack = 1'b0;

    // 1. reset
    cycle();
    chk("rst_irq", {15'b0, interrupt}, 16'h0000);
    chk("rst_ovf", {15'b0, overflow}, 16'h0000);
    chk("rst_stat", in_port, 16'h2000);
    cycle();
    rst = 1'b1;
    cycle();
    status_is("post_rst_stat", 16'h2000);

    // 2. single push, interrupt handshake, pop
    push(16'h00A1);
    chk("irq_lat0", {15'b0, interrupt}, 16'h0000);
    head_is("head_a1", 16'h00A1);
    cycle();
    chk("irq_lat1", {15'b0, interrupt}, 16'h0001);
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
    chk("irq_ack", {15'b0, interrupt}, 16'h0000);
    head_is("head_a1_b", 16'h00A1);
    rd(DATA_PORT);
    chk("empty_head", in_port, 16'h0000);
    status_is("empty_stat", 16'h2000);
    cycle();
    chk("irq_stays0", {15'b0, interrupt}, 16'h0000);

    // 3. fill, overflow, status clear, drain in order
    for (int i = 1; i <= 8; i++) push(16'(i));
    status_is("full_stat", 16'h4008);
    push(16'h0009);
    chk("ovf_set", {15'b0, overflow}, 16'h0001);
    status_is("ovf_stat", 16'hC008);
    rd(STAT_PORT);
    chk("ovf_clr", {15'b0, overflow}, 16'h0000);
    for (int i = 1; i <= 8; i++) begin
      head_is($sformatf("drain_%0d", i), 16'(i));
      rd(DATA_PORT);
    end
    status_is("drained_stat", 16'h2000);
    chk("req_holds", {15'b0, interrupt}, 16'h0001);
    settle_irq();
    cycle();
    chk("irq_idle3", {15'b0, interrupt}, 16'h0000);

    // 4. push and pop together while full
    for (int i = 1; i <= 8; i++) push(16'h0010 + 16'(i));
    head_is("full_head", 16'h0011);
    wr_tick = 1'b1; wr_data = 16'h0055;
    rd(DATA_PORT);
    wr_tick = 1'b0;
    status_is("pp_stat", 16'h4008);
    chk("pp_ovf", {15'b0, overflow}, 16'h0000);
    for (int i = 2; i <= 8; i++) begin
      head_is($sformatf("pp_drain_%0d", i), 16'h0010 + 16'(i));
      rd(DATA_PORT);
    end
    head_is("pp_last", 16'h0055);
    rd(DATA_PORT);
    status_is("pp_empty", 16'h2000);
    settle_irq();

    // 5. pointer wrap
    for (int i = 0; i < 5; i++) push(16'h0100 + 16'(i));
    status_is("wrap_cnt5", 16'h0005);
    for (int i = 0; i < 5; i++) begin
      head_is($sformatf("wrapA_%0d", i), 16'h0100 + 16'(i));
      rd(DATA_PORT);
    end
    for (int i = 0; i < 6; i++) push(16'h0200 + 16'(i));
    for (int i = 0; i < 6; i++) begin
      head_is($sformatf("wrapB_%0d", i), 16'h0200 + 16'(i));
      rd(DATA_PORT);
    end
    status_is("wrap_end", 16'h2000);
    settle_irq();
    cycle();

    // 6. re-request after service, then asynchronous reset
    push(16'h00B1);
    push(16'h00B2);
    chk("req6", {15'b0, interrupt}, 16'h0001);
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
    chk("svc6", {15'b0, interrupt}, 16'h0000);
    head_is("head_b1", 16'h00B1);
    rd(DATA_PORT);
    chk("idle6", {15'b0, interrupt}, 16'h0000);
    cycle();
    chk("rereq6", {15'b0, interrupt}, 16'h0001);
    head_is("head_b2", 16'h00B2);
    for (int i = 0; i < 8; i++) push(16'h00C0 + 16'(i));
    chk("ovf6", {15'b0, overflow}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    chk("arst_irq", {15'b0, interrupt}, 16'h0000);
    chk("arst_ovf", {15'b0, overflow}, 16'h0000);
    status_is("arst_stat", 16'h2000);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    push(16'h00D1);
    head_is("post_arst_head", 16'h00D1);
    status_is("post_arst_stat", 16'h0001);
    chk("post_arst_irq0", {15'b0, interrupt}, 16'h0000);
    cycle();
    chk("post_arst_irq1", {15'b0, interrupt}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/port_in_fifo.md
Name: port_in_fifo

Overview:
Processor-side input peripheral for the TramelBlaze port bus. It is the read-direction counterpart of the port-write output registers.
- Buffers 16-bit event words, for example debounced/PED-ticked switch or step samples, in a small FIFO.
- Presents FIFO data and a status word on IN_PORT, decoded by PORT_ID.
- Pops on READ_STROBE.
- Raises INTERRUPT while data is pending, with a request/acknowledge handshake on INTERRUPT_ACK. This replaces the standalone SR-flop interrupt latch.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, 2..16.
- DATA_PORT, 16'h0002, PORT_ID that reads and pops the FIFO head.
- STAT_PORT, 16'h0003, PORT_ID that reads the status word and clears overflow.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low: logic 0 resets the block.
- wr_tick  in  1  single-cycle push request; one word per cycle high.
- wr_data  in  16  word pushed when wr_tick=1.
- port_id  in  16  processor PORT_ID.
- read_strobe  in  1  processor READ_STROBE.
- interrupt_ack  in  1  processor INTERRUPT_ACK.
- in_port  out  16  data to processor IN_PORT.
- interrupt  out  1  interrupt request to processor INTERRUPT.
- overflow  out  1  sticky flag: a push was dropped.

Behaviour:
- Reset (rst=0, async): rd_ptr=0, wr_ptr=0, count=0, overflow=0, interrupt=0, state=IDLE. FIFO RAM contents don't-care.
- Terms:
  - rd_data = read_strobe & (port_id==DATA_PORT).
  - rd_stat = read_strobe & (port_id==STAT_PORT).
  - empty = (count==0); full = (count==DEPTH).
- in_port is a combinational mux on port_id, independent of read_strobe:
  - DATA_PORT: head entry if !empty, else 16'h0000.
  - STAT_PORT: {overflow, full, empty, 8'b0, count[4:0]}.
  - any other port_id: 16'h0000.
- Push:
  - Accepted at a clk edge when wr_tick & (!full | pop).
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs at a clk edge when rd_data & !empty; rd_ptr increments modulo DEPTH.
  - A data read while empty returns 0 and changes nothing.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, even when full. No overflow in that case.
  - count never exceeds DEPTH and never goes below 0.
- Overflow:
  - Set at the edge where wr_tick=1, full=1 and no pop; the word is dropped.
  - Cleared at the edge of rd_stat.
  - Set and clear in the same cycle: set wins.
  - interrupt depends only on FIFO occupancy, not on overflow.
- Interrupt FSM, registered, interrupt=1 only in REQ:
  - IDLE -> REQ when !empty, evaluated on current count. interrupt rises 1 cycle after the first push lands.
  - REQ -> SERVICE on interrupt_ack. interrupt drops at that edge.
  - REQ holds otherwise, even if the FIFO empties via polling reads. The ISR sees empty status and returns.
  - SERVICE -> IDLE on rd_data (with or without a pop) or rd_stat. If entries remain, IDLE -> REQ again on the following cycle.
  - interrupt_ack in IDLE or SERVICE is ignored.
- Latency:
  - push to visibility on in_port(DATA_PORT): 1 cycle.
  - pop to next head visible: 1 cycle.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0. Order is preserved across the wrap.
- Mid-operation reset: all state is cleared immediately and asynchronously. interrupt and overflow go to 0 without waiting for clk. The first push after rst deasserts behaves as from power-up.

Test Plan:
1. Reset → overflow, interrupt and count all 0. Release rst, port_id=STAT_PORT → in_port=16'h2000 (empty=1, count=0).
2. Push 16'h00A1 → interrupt=1 one cycle later. Pulse interrupt_ack → interrupt=0. port_id=DATA_PORT → in_port=16'h00A1. read_strobe pulse → count=0, in_port=0, interrupt stays 0.
3. Push 16'h0001..16'h0008 (DEPTH=8) → status=16'h4008 (full). Push 16'h0009 → word dropped, overflow=1, status=16'hC008. Status read → overflow=0. Eight data reads → 16'h0001..16'h0008 in order.
4. With FIFO full, assert wr_tick=1 (16'h0055) and a data read in the same cycle → count stays 8, overflow stays 0, 16'h0055 is read last.
5. Wrap check: push 5, pop 5, push 6, pop 6 → values return in order, pointers wrap, count ends at 0.
6. Push 2 words → REQ; ack → SERVICE; one data read → IDLE, then interrupt=1 again next cycle because 1 entry remains. Assert rst=0 mid-sequence → interrupt=0 and count=0 immediately.
